// File: rtl/avalon_ram_master.sv
// rtl/avalon_ram_master.sv - wide-row Avalon-MM initiator for one 32-bit arithmetic test RAM slave
// Optional macro POLL_TIMEOUT_EN: give up status polling after TIMEOUT_CYCLES and report rsp_error.
module avalon_ram_master #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 8,
  parameter int AV_ADDR_WIDTH  = 5,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     avalon_clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_row,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  output logic                     avm_read,
  output logic                     avm_write,
  output logic [AV_ADDR_WIDTH-1:0] avm_address,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata
);

  localparam int WORDS = DATA_WIDTH / 32;
  localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);
  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  localparam logic [AV_ADDR_WIDTH-1:0] ADDR_ROW    = AV_ADDR_WIDTH'(8);
  localparam logic [AV_ADDR_WIDTH-1:0] ADDR_CMD    = AV_ADDR_WIDTH'(9);
  localparam logic [AV_ADDR_WIDTH-1:0] ADDR_STATUS = AV_ADDR_WIDTH'(10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_SET_ROW,
    S_CMD,
    S_RD,
    S_RD_WAIT
  } state_t;

  state_t                   r_state;
  logic                     r_cmd_ready;
  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_avm_read;
  logic                     r_avm_write;
  logic [AV_ADDR_WIDTH-1:0] r_avm_address;
  logic [31:0]              r_avm_writedata;
  logic                     r_is_write;
  logic                     r_is_poll;
  logic [ADDR_WIDTH-1:0]    r_row;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [DATA_WIDTH-1:0]    r_rd_buf;
  logic [3:0]               r_word;
  logic [1:0]               r_lat;

  logic [3:0]               w_next_word;
  logic [DATA_WIDTH-1:0]    w_rd_merged;

`ifdef POLL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_error;
  assign rsp_error = r_rsp_error;
`else
  assign rsp_error = 1'b0;
`endif

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_address   = r_avm_address;
  assign avm_writedata = r_avm_writedata;

  assign w_next_word = r_word + 4'd1;

  // Read row being assembled, with the word now on avm_readdata folded in.
  always_comb begin
    w_rd_merged = r_rd_buf;
    w_rd_merged[r_word*32 +: 32] = avm_readdata;
  end

  always_ff @(posedge avalon_clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cmd_ready     <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_is_write      <= 1'b0;
      r_is_poll       <= 1'b0;
      r_row           <= '0;
      r_data          <= '0;
      r_rd_buf        <= '0;
      r_word          <= '0;
      r_lat           <= '0;
`ifdef POLL_TIMEOUT_EN
      r_to_cnt        <= '0;
      r_rsp_error     <= 1'b0;
`endif
    end else begin
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef POLL_TIMEOUT_EN
      r_rsp_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_is_write  <= cmd_write;
            r_row       <= cmd_row;
            r_data      <= cmd_data;
            r_word      <= '0;
            r_avm_write <= 1'b1;
            if (cmd_write) begin
              r_state         <= S_WR_DATA;
              r_avm_address   <= '0;
              r_avm_writedata <= cmd_data[31:0];
            end else begin
              r_state         <= S_SET_ROW;
              r_avm_address   <= ADDR_ROW;
              r_avm_writedata <= 32'(cmd_row);
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_WR_DATA: begin
          r_avm_write <= 1'b1;
          if (r_word == LAST_WORD) begin
            r_state         <= S_SET_ROW;
            r_avm_address   <= ADDR_ROW;
            r_avm_writedata <= 32'(r_row);
          end else begin
            r_word          <= w_next_word;
            r_avm_address   <= AV_ADDR_WIDTH'(w_next_word);
            r_avm_writedata <= r_data[w_next_word*32 +: 32];
          end
        end

        S_SET_ROW: begin
          r_state         <= S_CMD;
          r_avm_write     <= 1'b1;
          r_avm_address   <= ADDR_CMD;
          r_avm_writedata <= r_is_write ? 32'd1 : 32'd2;
        end

        S_CMD: begin
          if (r_is_write) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
          end else begin
            r_state       <= S_RD;
            r_avm_read    <= 1'b1;
            r_avm_address <= ADDR_STATUS;
            r_is_poll     <= 1'b1;
`ifdef POLL_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
          end
        end

        S_RD: begin
          r_state <= S_RD_WAIT;
          r_lat   <= 2'd1;
        end

        S_RD_WAIT: begin
          if (r_lat != LAT) begin
            r_lat <= r_lat + 2'd1;
          end else if (r_is_poll) begin
            // Busy: re-poll straight away; idle: start fetching staging words.
            r_state    <= S_RD;
            r_avm_read <= 1'b1;
            if (avm_readdata[0]) begin
              r_avm_address <= ADDR_STATUS;
            end else begin
              r_is_poll     <= 1'b0;
              r_word        <= '0;
              r_avm_address <= '0;
            end
          end else begin
            r_rd_buf <= w_rd_merged;
            if (r_word == LAST_WORD) begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rd_merged;
            end else begin
              r_state       <= S_RD;
              r_avm_read    <= 1'b1;
              r_word        <= w_next_word;
              r_avm_address <= AV_ADDR_WIDTH'(w_next_word);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef POLL_TIMEOUT_EN
      if ((r_state == S_RD || r_state == S_RD_WAIT) && r_is_poll) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TO_LAST) begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b1;
          r_avm_read  <= 1'b0;
          r_is_poll   <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
